// File: rtl/ex_stage_md.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ex_stage_md                                                       |
// | Brief  : RV32 execute stage with ALU, forwarding, branch resolve, PC       |
// |          target and an RV32M multiply / iterative radix-2 divide unit.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ex_stage_md #(
  parameter int XLEN             = 32,
  parameter int MUL_STAGES       = 2,
  parameter int FAST_DIV_SPECIAL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [1:0]      forwarda,
  input  logic [1:0]      forwardb,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] immext,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pcplus4,
  input  logic [XLEN-1:0] result_w,
  input  logic [XLEN-1:0] aluresult_m,
  input  logic            alusrc,
  input  logic [3:0]      alucontrol,
  input  logic            branch,
  input  logic            jump,
  input  logic            md_valid,
  input  logic [2:0]      md_op,
  output logic [XLEN-1:0] exresult,
  output logic [XLEN-1:0] writedata,
  output logic [XLEN-1:0] pctarget,
  output logic            pcsrc,
  output logic            md_stall,
  output logic            md_done
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CW-1:0]   c_cnt_div = CW'(XLEN - 1);
  localparam logic [CW-1:0]   c_cnt_mul = CW'(MUL_STAGES - 1);
  localparam logic [XLEN-1:0] c_min_neg = {1'b1, {(XLEN-1){1'b0}}};

  // ALU opcodes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [3:0] ALU_LINK = 4'd15;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] srca, srcb_fwd, srcb, aluresult;
  logic            zero;

  // Forwarding muxes and immediate select
  always_comb begin
    case (forwarda)
      2'b01:   srca = result_w;
      2'b10:   srca = aluresult_m;
      default: srca = rd1;
    endcase
    case (forwardb)
      2'b01:   srcb_fwd = result_w;
      2'b10:   srcb_fwd = aluresult_m;
      default: srcb_fwd = rd2;
    endcase
    srcb = alusrc ? immext : srcb_fwd;
  end

  // Single-cycle ALU
  always_comb begin
    case (alucontrol)
      ALU_ADD:  aluresult = srca + srcb;
      ALU_SUB:  aluresult = srca - srcb;
      ALU_AND:  aluresult = srca & srcb;
      ALU_OR:   aluresult = srca | srcb;
      ALU_XOR:  aluresult = srca ^ srcb;
      ALU_SLT:  aluresult = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      ALU_SLTU: aluresult = {{(XLEN-1){1'b0}}, (srca < srcb)};
      ALU_SLL:  aluresult = srca << srcb[CW-1:0];
      ALU_SRL:  aluresult = srca >> srcb[CW-1:0];
      ALU_SRA:  aluresult = $signed(srca) >>> srcb[CW-1:0];
      ALU_LUI:  aluresult = srcb;
      ALU_LINK: aluresult = pcplus4;
      default:  aluresult = srca + srcb;
    endcase
    zero = (aluresult == '0);
  end

  logic [XLEN-1:0]   m_a, m_b;
  logic [2:0]        m_op;
  logic [2*XLEN-1:0] m_a_ext, m_b_ext, m_prod;
  logic [XLEN-1:0]   mul_res;

  // Multiplier: live operands on the issue cycle (single-stage case), latched afterwards
  always_comb begin
    m_a     = (state_q == ST_IDLE) ? srca  : a_q;
    m_b     = (state_q == ST_IDLE) ? srcb  : b_q;
    m_op    = (state_q == ST_IDLE) ? md_op : op_q;
    // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed
    m_a_ext = {{XLEN{m_a[XLEN-1] & ((m_op[1:0] == 2'b01) | (m_op[1:0] == 2'b10))}}, m_a};
    m_b_ext = {{XLEN{m_b[XLEN-1] & (m_op[1:0] == 2'b01)}}, m_b};
    m_prod  = m_a_ext * m_b_ext;
    mul_res = (m_op[1:0] == 2'b00) ? m_prod[XLEN-1:0] : m_prod[2*XLEN-1:XLEN];
  end

  logic            div_signed, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  // Divide issue-time decode: magnitudes and the two RISC-V special cases
  always_comb begin
    div_signed  = ~md_op[0];
    div_zero    = (srcb == '0);
    div_ovf     = div_signed & (srca == c_min_neg) & (srcb == '1);
    mag_a       = (div_signed & srca[XLEN-1]) ? (~srca + 1'b1) : srca;
    mag_b       = (div_signed & srcb[XLEN-1]) ? (~srcb + 1'b1) : srcb;
    if (div_zero)
      special_res = md_op[1] ? srca : '1;
    else
      special_res = md_op[1] ? '0 : srca;
  end

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_n, quo_n, quo_f, rem_f;

  // One restoring shift/subtract step plus final sign correction
  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    if (!trial[XLEN]) begin
      rem_n = trial[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_n = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
      quo_n = {quo_q[XLEN-2:0], 1'b0};
    end
    quo_f = qneg_q ? (~quo_n + 1'b1) : quo_n;
    rem_f = rneg_q ? (~rem_n + 1'b1) : rem_n;
  end

  // M-unit sequencer: IDLE -> MUL/DIV -> DONE -> IDLE, flush always returns to IDLE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (md_valid && !flush) begin
          a_d  = srca;
          b_d  = srcb;
          op_d = md_op;
          if (!md_op[2]) begin
            if (MUL_STAGES == 1) begin
              state_d  = ST_DONE;
              result_d = mul_res;
            end else begin
              state_d = ST_MUL;
              cnt_d   = c_cnt_mul;
            end
          end else if ((FAST_DIV_SPECIAL != 0) && (div_zero || div_ovf)) begin
            state_d  = ST_DONE;
            result_d = special_res;
          end else begin
            state_d = ST_DIV;
            cnt_d   = c_cnt_div;
            quo_d   = mag_a;
            rem_d   = '0;
            dvs_d   = mag_b;
            // a zero divisor must still yield an all-ones quotient
            qneg_d  = div_signed & (srca[XLEN-1] ^ srcb[XLEN-1]) & ~div_zero;
            rneg_d  = div_signed & srca[XLEN-1];
          end
        end
      end
      ST_MUL: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d  = ST_DONE;
          result_d = mul_res;
        end
      end
      ST_DIV: begin
        quo_d = quo_n;
        rem_d = rem_n;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          result_d = op_q[1] ? rem_f : quo_f;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  // Output drive; reset acts like flush on the handshake outputs
  always_comb begin
    md_stall  = md_valid & (state_q != ST_DONE) & ~flush & ~reset;
    md_done   = (state_q == ST_DONE) & ~flush & ~reset;
    exresult  = md_done ? result_q : aluresult;
    writedata = srcb_fwd;
    pctarget  = pc + immext;
    pcsrc     = jump | (branch & zero);
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_md.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ex_stage_md                                                    |
// | Brief  : Directed self-checking bench for ex_stage_md (XLEN=32,            |
// |          MUL_STAGES=2, FAST_DIV_SPECIAL=1).                                |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_ex_stage_md;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [1:0]  forwarda, forwardb;
  logic [31:0] rd1, rd2, immext, pc, pcplus4, result_w, aluresult_m;
  logic        alusrc, branch, jump, md_valid;
  logic [3:0]  alucontrol;
  logic [2:0]  md_op;
  logic [31:0] exresult, writedata, pctarget;
  logic        pcsrc, md_stall, md_done;

  int total = 0;
  int bad   = 0;

  ex_stage_md #(.XLEN(32), .MUL_STAGES(2), .FAST_DIV_SPECIAL(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .forwarda(forwarda), .forwardb(forwardb),
    .rd1(rd1), .rd2(rd2), .immext(immext), .pc(pc), .pcplus4(pcplus4),
    .result_w(result_w), .aluresult_m(aluresult_m),
    .alusrc(alusrc), .alucontrol(alucontrol), .branch(branch), .jump(jump),
    .md_valid(md_valid), .md_op(md_op),
    .exresult(exresult), .writedata(writedata), .pctarget(pctarget),
    .pcsrc(pcsrc), .md_stall(md_stall), .md_done(md_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one M-op just after a posedge, count stall cycles until md_done,
  // check result and stall count, then drop md_valid after DONE.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] fa, input bit bubble,
                        input logic [31:0] exp, input int exp_st);
    int  st;
    bit  seen;
    st   = 0;
    seen = 1'b0;
    md_valid = 1'b1;
    md_op    = op;
    forwarda = fa;
    if (fa == 2'b10) aluresult_m = a; else rd1 = a;
    rd2 = b;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (md_done) seen = 1'b1;
      else begin
        if (md_stall) st++;
        @(posedge clk);
        #1;
        if (bubble) aluresult_m = 32'hDEAD_BEEF;
      end
    end
    chk({tag, " done"}, {31'd0, seen}, 32'd1);
    chk({tag, " result"}, exresult, exp);
    chk({tag, " stalls"}, st, exp_st);
    @(posedge clk);
    #1;
    md_valid = 1'b0;
    forwarda = 2'b00;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    forwarda = 2'b00; forwardb = 2'b00;
    rd1 = '0; rd2 = '0; immext = '0; pc = '0; pcplus4 = '0;
    result_w = '0; aluresult_m = '0;
    alusrc = 1'b0; alucontrol = 4'd0; branch = 1'b0; jump = 1'b0;
    md_valid = 1'b1; md_op = OP_MUL;

    // Reset: handshake outputs held low even with md_valid asserted
    @(negedge clk);
    chk("reset stall", {31'd0, md_stall}, 32'd0);
    chk("reset done",  {31'd0, md_done},  32'd0);
    @(posedge clk); #1;
    md_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Combinational ALU / target / branch / forwarding paths
    rd1 = 32'd5; immext = 32'd3; alusrc = 1'b1; alucontrol = 4'd0; pc = 32'h100;
    #1;
    chk("alu add imm", exresult, 32'd8);
    chk("pctarget",    pctarget, 32'h103);
    rd1 = 32'd9; rd2 = 32'd9; alusrc = 1'b0; alucontrol = 4'd1; branch = 1'b1;
    #1;
    chk("beq taken", {31'd0, pcsrc}, 32'd1);
    rd2 = 32'd8;
    #1;
    chk("beq not taken", {31'd0, pcsrc}, 32'd0);
    forwardb = 2'b01; result_w = 32'h55;
    #1;
    chk("writedata fwd", writedata, 32'h55);
    forwardb = 2'b00; branch = 1'b0; alucontrol = 4'd0;
    @(posedge clk); #1;

    // Multiplies
    run_md("mul 7x-3", OP_MUL,    32'd7,        32'hFFFF_FFFD, 2'b00, 1'b0, 32'hFFFF_FFEB, 2);
    run_md("mulh",     OP_MULH,   32'h8000_0000, 32'h8000_0000, 2'b00, 1'b0, 32'h4000_0000, 2);
    run_md("mulhu",    OP_MULHU,  32'h8000_0000, 32'h8000_0000, 2'b00, 1'b0, 32'h4000_0000, 2);
    run_md("mulhsu",   OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 2'b00, 1'b0, 32'hC000_0000, 2);

    // Regular divides (33 stall cycles)
    run_md("divu 100/7", OP_DIVU, 32'd100, 32'd7, 2'b00, 1'b0, 32'd14, 33);
    run_md("remu 100/7", OP_REMU, 32'd100, 32'd7, 2'b00, 1'b0, 32'd2,  33);
    run_md("div -20/3",  OP_DIV,  32'hFFFF_FFEC, 32'd3, 2'b00, 1'b0, 32'hFFFF_FFFA, 33);
    run_md("rem -20/3",  OP_REM,  32'hFFFF_FFEC, 32'd3, 2'b00, 1'b0, 32'hFFFF_FFFE, 33);

    // Special cases (1 stall cycle)
    run_md("div ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'h8000_0000, 1);
    run_md("rem ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'h0,         1);
    run_md("divu x/0", OP_DIVU, 32'd123, 32'd0, 2'b00, 1'b0, 32'hFFFF_FFFF, 1);
    run_md("remu 5/0", OP_REMU, 32'd5,   32'd0, 2'b00, 1'b0, 32'd5,         1);

    // Forwarded rs1 from M stage, which then becomes a bubble
    run_md("div fwd", OP_DIV, 32'd50, 32'd5, 2'b10, 1'b1, 32'd10, 33);

    // Flush during DIV iteration 10
    md_valid = 1'b1; md_op = OP_DIVU; rd1 = 32'd100; rd2 = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    chk("flush stall", {31'd0, md_stall}, 32'd0);
    chk("flush done",  {31'd0, md_done},  32'd0);
    @(posedge clk); #1;
    flush = 1'b0; md_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post flush done", {31'd0, md_done}, 32'd0);
    end
    @(posedge clk); #1;
    run_md("mul after flush", OP_MUL, 32'd3, 32'd4, 2'b00, 1'b0, 32'd12, 2);

    // Reset asserted mid-MUL
    md_valid = 1'b1; md_op = OP_MUL; rd1 = 32'd9; rd2 = 32'd9;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("reset mid stall", {31'd0, md_stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; md_valid = 1'b0;
    @(negedge clk);
    chk("post reset done", {31'd0, md_done}, 32'd0);
    @(posedge clk); #1;
    run_md("mul after reset", OP_MUL, 32'd3, 32'd4, 2'b00, 1'b0, 32'd12, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parametrised execute stage for the 5-stage RV32 pipeline. Adds RV32M multiply/divide to the existing ALU, forwarding, branch-resolve and PC-target path.
- Single-cycle ops are unchanged (combinational). Multiplies use a MUL_STAGES-cycle latency. Divides use an iterative radix-2 unit.
- The stage raises a stall to the hazard unit while an M-op is in flight and latches its forwarded operands at issue.

Parameters:
- XLEN, 32, datapath width; must be 32 or 64.
- MUL_STAGES, 2, multiply latency in cycles (1..4) = stall cycles per MUL* op.
- FAST_DIV_SPECIAL, 1, when 1 divide-by-zero and overflow complete in 1 stall cycle; when 0 they take the full iterative path.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill the EX instruction (mispredict / trap); aborts any M-op
- forwarda, forwardb  in  2 each  00 register file, 01 result_w, 10 aluresult_m
- rd1, rd2, immext, pc, pcplus4  in  XLEN each  ID/EX operands
- result_w, aluresult_m  in  XLEN each  forwarding sources
- alusrc  in  1  srcb = immext when 1
- alucontrol  in  4  existing ALU op encoding
- branch, jump  in  1 each  control bits
- md_valid  in  1  EX instruction is an M-extension op
- md_op  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- exresult  out  XLEN  ALU result, or M-op result in DONE
- writedata  out  XLEN  forwarded rs2
- pctarget  out  XLEN  pc + immext
- pcsrc  out  1  jump | (branch & zero)
- md_stall  out  1  hold F/D/E and bubble M
- md_done  out  1  M-op result valid this cycle

Behaviour:
- Operand select: srca/srcb are chosen by forwarda/forwardb as listed under Ports; srcb is then muxed with immext by alusrc. The ALU, pctarget and pcsrc paths are combinational with no latency.
- FSM states: IDLE, MUL, DIV, DONE. Reset forces IDLE, clears counters, the operand latch and the result register. All outputs are 0 during reset except combinational pass-through.
- md_stall = md_valid & (state != DONE) & ~flush.
- IDLE, md_valid=1, no flush:
  - Latch srca/srcb and md_op.
  - Any MUL* op: go to MUL with cnt = MUL_STAGES-1. If MUL_STAGES=1, go straight to DONE.
  - DIV*/REM* with divisor 0, or signed overflow (-2^(XLEN-1) / -1), and FAST_DIV_SPECIAL=1: go to DONE.
  - Otherwise: go to DIV with cnt = XLEN-1. Signed ops operate on magnitudes; sign fix is applied at DONE.
- MUL: decrement cnt each cycle; go to DONE when cnt reaches 0. The product is the full 2*XLEN result.
  - MUL returns the low half.
  - MULH, MULHSU, MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- DIV: one restoring shift/subtract per cycle; go to DONE after XLEN iterations.
- Stall cycle counts: MUL* = MUL_STAGES; regular div = XLEN+1; special-case div = 1.
- DONE:
  - md_done=1, md_stall=0, exresult = result register.
  - Next cycle go to IDLE; the instruction advances.
  - md_valid is low that next cycle unless back-to-back M-ops are issued; a back-to-back op is accepted from IDLE.
- Special results:
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Overflow: DIV returns -2^(XLEN-1); REM returns 0.
- Operand latching is mandatory. M becomes bubbles during a stall, so aluresult_m changes; M-op results use the issue-cycle forwarded values.
- flush: in any state, the next state is IDLE, md_stall=0 in the same cycle, md_done is suppressed and the result is discarded.
- reset mid-operation behaves identically to flush and also clears registers.

Test Plan:
- MUL: srca=7, srcb=-3 (0xFFFFFFFD), MUL_STAGES=2 -> md_stall high 2 cycles, then md_done, exresult=0xFFFFFFEB.
- MULH, MULHU, MULHSU on 0x80000000 × 0x80000000 -> 0x40000000, 0x40000000, 0xC0000000 respectively.
- DIVU 100/7 -> md_stall exactly 33 cycles, exresult=14; REMU on the same operands -> 2.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 1 stall cycle; REM -> 0. DIVU x/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- DIV with rs1 forwarded from aluresult_m=50, rs2=5 and the M stage bubbled afterwards -> exresult=10.
- Flush at iteration 10 of a DIV -> md_stall drops the same cycle, no md_done. A following MUL 3×4 -> 12 with normal latency. Reset asserted mid-MUL gives the same result.
